// File: rtl/data_producer_pkg.sv
// Shared types and constants for the AXI-Stream test-pattern producer.
package data_producer_pkg;

    // Producer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Width of one replicated counter lane in TDATA
    localparam int unsigned LANE_W = 32;

    // Data width must be a whole number of 32-bit lanes
    function automatic bit dw_ok(input int unsigned dw);
        return (dw >= LANE_W) && ((dw % LANE_W) == 0);
    endfunction

    // Packet length must fit the 16-bit beat-within-packet index
    function automatic bit beats_ok(input int unsigned beats);
        return (beats >= 1) && (beats <= 65535);
    endfunction

    // Inter-packet gap must fit the 8-bit gap counter
    function automatic bit gap_ok(input int unsigned gap);
        return gap <= 255;
    endfunction

endpackage

// File: rtl/data_producer.sv
// AXI-Stream packet generator: emits runs of fixed-length packets whose
// data lanes all carry a free-running beat counter.
module data_producer
    import data_producer_pkg::*;
#(
    parameter int unsigned DW           = 512,
    parameter int unsigned PACKET_BEATS = 16,
    parameter int unsigned GAP_CYCLES   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [31:0]   packet_count,
    output logic [DW-1:0] AXIS_TX_TDATA,
    output logic          AXIS_TX_TVALID,
    output logic          AXIS_TX_TLAST,
    input  logic          AXIS_TX_TREADY,
    output logic          busy,
    output logic [31:0]   packets_sent
);

    localparam int unsigned LANES    = DW / LANE_W;
    localparam logic [15:0] LAST_IDX = 16'(PACKET_BEATS - 1);
    localparam logic [7:0]  GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (!dw_ok(DW)) begin : g_bad_dw
        $error("data_producer: DW must be a multiple of 32 and at least 32");
    end
    if (!beats_ok(PACKET_BEATS)) begin : g_bad_beats
        $error("data_producer: PACKET_BEATS must be in 1..65535");
    end
    if (!gap_ok(GAP_CYCLES)) begin : g_bad_gap
        $error("data_producer: GAP_CYCLES must be in 0..255");
    end

    state_t      state;
    logic [31:0] beat_cnt;
    logic [15:0] beat_idx;
    logic [7:0]  gap_cnt;
    logic [31:0] pkt_target;
    logic        stop_pend;

    logic [31:0] beat_next;
    logic        handshake;
    logic        target_hit;

    // Next counter value, beat acceptance and run-length completion
    assign beat_next  = beat_cnt + 32'd1;
    assign handshake  = AXIS_TX_TVALID & AXIS_TX_TREADY;
    assign target_hit = (pkt_target != '0) && ((packets_sent + 32'd1) == pkt_target);
    assign busy       = (state != ST_IDLE);

    // Run control FSM; all stream outputs are registered here so TREADY
    // only ever influences the next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            AXIS_TX_TDATA  <= '0;
            AXIS_TX_TVALID <= 1'b0;
            AXIS_TX_TLAST  <= 1'b0;
            packets_sent   <= '0;
            beat_cnt       <= '0;
            beat_idx       <= '0;
            gap_cnt        <= '0;
            pkt_target     <= '0;
            stop_pend      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_SEND;
                        pkt_target     <= packet_count;
                        beat_cnt       <= '0;
                        beat_idx       <= '0;
                        packets_sent   <= '0;
                        stop_pend      <= 1'b0;
                        AXIS_TX_TDATA  <= '0;
                        AXIS_TX_TVALID <= 1'b1;
                        AXIS_TX_TLAST  <= (LAST_IDX == '0);
                    end
                end
                ST_SEND: begin
                    if (stop) stop_pend <= 1'b1;
                    if (handshake) begin
                        beat_cnt      <= beat_next;
                        AXIS_TX_TDATA <= {LANES{beat_next}};
                        if (AXIS_TX_TLAST) begin
                            beat_idx <= '0;
                            if (packets_sent != '1) packets_sent <= packets_sent + 32'd1;
                            // a stop arriving with the last beat ends the run here
                            if (stop_pend || stop || target_hit) begin
                                state          <= ST_IDLE;
                                AXIS_TX_TVALID <= 1'b0;
                                AXIS_TX_TLAST  <= 1'b0;
                            end else if (GAP_CYCLES != 0) begin
                                state          <= ST_GAP;
                                gap_cnt        <= '0;
                                AXIS_TX_TVALID <= 1'b0;
                                AXIS_TX_TLAST  <= 1'b0;
                            end else begin
                                AXIS_TX_TLAST  <= (LAST_IDX == '0);
                            end
                        end else begin
                            beat_idx      <= beat_idx + 16'd1;
                            AXIS_TX_TLAST <= ((beat_idx + 16'd1) == LAST_IDX);
                        end
                    end
                end
                ST_GAP: begin
                    if (stop_pend || stop) begin
                        state <= ST_IDLE;
                    end else if (gap_cnt == GAP_LAST) begin
                        state          <= ST_SEND;
                        AXIS_TX_TVALID <= 1'b1;
                        AXIS_TX_TLAST  <= (LAST_IDX == '0);
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_producer.sv
// Directed bench for data_producer: one instance without gaps (A) and one
// with a three-cycle inter-packet gap (B), both 4-beat packets, 64-bit data.
module tb_data_producer;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_a = 1'b0;
    logic          start_b = 1'b0;
    logic          stop = 1'b0;
    logic          tready = 1'b1;
    logic [31:0]   packet_count = '0;

    logic [DW-1:0] tdata_a, tdata_b;
    logic          tvalid_a, tvalid_b, tlast_a, tlast_b, busy_a, busy_b;
    logic [31:0]   sent_a, sent_b;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q_data[$];
    bit            q_last[$];
    int            q_cyc[$];
    int            unstable;
    bit            ended;

    data_producer #(.DW(DW), .PACKET_BEATS(4), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop),
        .packet_count(packet_count),
        .AXIS_TX_TDATA(tdata_a), .AXIS_TX_TVALID(tvalid_a), .AXIS_TX_TLAST(tlast_a),
        .AXIS_TX_TREADY(tready), .busy(busy_a), .packets_sent(sent_a)
    );

    data_producer #(.DW(DW), .PACKET_BEATS(4), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop),
        .packet_count(packet_count),
        .AXIS_TX_TDATA(tdata_b), .AXIS_TX_TVALID(tvalid_b), .AXIS_TX_TLAST(tlast_b),
        .AXIS_TX_TREADY(tready), .busy(busy_b), .packets_sent(sent_b)
    );

    always #5 clk = ~clk;

    // Records accepted beats from one instance until busy falls or the cycle
    // budget runs out; optionally toggles TREADY and pulses stop/start when a
    // given data value is on the bus. Called at posedge+1 just after start.
    task automatic collect(input bit use_b, input int max_cyc, input bit toggle,
                           input int stop_data, input int start_data);
        logic [DW-1:0] d, pd;
        bit v, l, b, pv, pl, pr, stop_sent, start_sent;
        q_data.delete(); q_last.delete(); q_cyc.delete();
        unstable = 0; ended = 0;
        pv = 0; pl = 0; pr = 1; pd = '0; stop_sent = 0; start_sent = 0;
        for (int c = 0; c < max_cyc; c++) begin
            d = use_b ? tdata_b  : tdata_a;
            v = use_b ? tvalid_b : tvalid_a;
            l = use_b ? tlast_b  : tlast_a;
            b = use_b ? busy_b   : busy_a;
            if (c > 0 && !b) begin
                ended = 1;
                break;
            end
            tready = toggle ? ((c % 2) == 0) : 1'b1;
            if (pv && !pr && (!v || d !== pd || l !== pl)) unstable++;
            if (v && tready) begin
                q_data.push_back(d); q_last.push_back(l); q_cyc.push_back(c);
            end
            if (v && stop_data >= 0 && !stop_sent && d[31:0] == 32'(stop_data)) begin
                stop = 1'b1; stop_sent = 1;
            end
            if (v && start_data >= 0 && !start_sent && d[31:0] == 32'(start_data)) begin
                start_a = 1'b1; start_sent = 1;
            end
            pv = v; pl = l; pd = d; pr = tready;
            @(posedge clk); #1;
            stop = 1'b0; start_a = 1'b0;
        end
        tready = 1'b1;
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #2;
        checks++;
        if (tvalid_a !== 1'b0 || tlast_a !== 1'b0 || tdata_a !== '0 || busy_a !== 1'b0 || sent_a !== '0) begin
            errors++;
            $display("FAIL reset_a: got valid=%b last=%b data=%h busy=%b sent=%0d, expected all zero",
                     tvalid_a, tlast_a, tdata_a, busy_a, sent_a);
        end
        checks++;
        if (tvalid_b !== 1'b0 || busy_b !== 1'b0 || sent_b !== '0) begin
            errors++;
            $display("FAIL reset_b: got valid=%b busy=%b sent=%0d, expected all zero", tvalid_b, busy_b, sent_b);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        packet_count = 32'd2;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if (tvalid_a !== 1'b1 || tdata_a !== '0 || tlast_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_beat: got valid=%b data=%h last=%b, expected 1/0/0", tvalid_a, tdata_a, tlast_a);
        end
        collect(0, 60, 0, -1, -1);
        checks++;
        if (!ended) begin errors++; $display("FAIL basic_end: busy never fell, expected end of run"); end
        checks++;
        if (q_data.size() != 8) begin errors++; $display("FAIL basic_count: got %0d beats expected 8", q_data.size()); end
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== {2{32'(i)}} || q_last[i] !== ((i % 4) == 3) || q_cyc[i] != i) begin
                errors++;
                $display("FAIL basic_beat%0d: got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                         i, q_data[i], q_last[i], q_cyc[i], {2{32'(i)}}, ((i % 4) == 3), i);
            end
        end
        checks++;
        if (sent_a !== 32'd2 || busy_a !== 1'b0) begin
            errors++; $display("FAIL basic_sent: got sent=%0d busy=%b expected 2/0", sent_a, busy_a);
        end
        @(posedge clk); #1;
        checks++;
        if (sent_a !== 32'd2) begin errors++; $display("FAIL basic_sent_hold: got %0d expected 2", sent_a); end
    endtask

    task automatic test_backpressure;
        packet_count = 32'd2;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        collect(0, 60, 1, -1, -1);
        checks++;
        if (!ended) begin errors++; $display("FAIL bp_end: busy never fell, expected end of run"); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", unstable); end
        checks++;
        if (q_data.size() != 8) begin errors++; $display("FAIL bp_count: got %0d beats expected 8", q_data.size()); end
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== {2{32'(i)}} || q_last[i] !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h last=%b expected data=%h last=%b",
                         i, q_data[i], q_last[i], {2{32'(i)}}, ((i % 4) == 3));
            end
        end
        checks++;
        if (sent_a !== 32'd2) begin errors++; $display("FAIL bp_sent: got %0d expected 2", sent_a); end
    endtask

    task automatic test_gap;
        packet_count = 32'd2;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        collect(1, 60, 0, -1, -1);
        checks++;
        if (!ended) begin errors++; $display("FAIL gap_end: busy never fell, expected end of run"); end
        checks++;
        if (q_data.size() != 8) begin
            errors++; $display("FAIL gap_count: got %0d beats expected 8", q_data.size());
        end else begin
            checks++;
            if (q_cyc[4] - q_cyc[3] - 1 != 3) begin
                errors++; $display("FAIL gap_len: got %0d idle cycles expected 3", q_cyc[4] - q_cyc[3] - 1);
            end
            checks++;
            if (q_cyc[3] != 3 || q_cyc[7] != q_cyc[4] + 3) begin
                errors++; $display("FAIL gap_packet_contig: got cyc3=%0d cyc7=%0d expected 3 and %0d", q_cyc[3], q_cyc[7], q_cyc[4] + 3);
            end
            checks++;
            if (q_data[4] !== {2{32'd4}} || q_last[7] !== 1'b1) begin
                errors++; $display("FAIL gap_data: got beat4=%h last7=%b expected %h/1", q_data[4], q_last[7], {2{32'd4}});
            end
        end
        checks++;
        if (sent_b !== 32'd2) begin errors++; $display("FAIL gap_sent: got %0d expected 2", sent_b); end
    endtask

    task automatic test_stop;
        packet_count = 32'd0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        collect(0, 60, 0, 5, -1);
        checks++;
        if (!ended) begin errors++; $display("FAIL stop_end: busy never fell, expected end of run"); end
        checks++;
        if (q_data.size() != 8) begin
            errors++; $display("FAIL stop_count: got %0d beats expected 8", q_data.size());
        end else begin
            checks++;
            if (q_data[7] !== {2{32'd7}} || q_last[7] !== 1'b1) begin
                errors++; $display("FAIL stop_last: got data=%h last=%b expected %h/1", q_data[7], q_last[7], {2{32'd7}});
            end
        end
        checks++;
        if (sent_a !== 32'd2) begin errors++; $display("FAIL stop_sent: got %0d expected 2", sent_a); end
    endtask

    task automatic test_start_stop_same;
        packet_count = 32'd2;
        start_a = 1'b1;
        stop = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        stop = 1'b0;
        // start pulse again while data 2 is on the bus; must be ignored
        collect(0, 60, 0, -1, 2);
        checks++;
        if (!ended) begin errors++; $display("FAIL ss_end: busy never fell, expected end of run"); end
        checks++;
        if (q_data.size() != 8) begin errors++; $display("FAIL ss_count: got %0d beats expected 8", q_data.size()); end
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== {2{32'(i)}}) begin
                errors++; $display("FAIL ss_beat%0d: got %h expected %h", i, q_data[i], {2{32'(i)}});
            end
        end
        checks++;
        if (sent_a !== 32'd2) begin errors++; $display("FAIL ss_sent: got %0d expected 2", sent_a); end
    endtask

    task automatic test_reset_mid;
        bit found;
        packet_count = 32'd2;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            if (tvalid_a && tdata_a[31:0] == 32'd2) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rmid_wait: beat 2 not seen within 10 cycles"); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (tvalid_a !== 1'b0 || tlast_a !== 1'b0 || tdata_a !== '0 || busy_a !== 1'b0 || sent_a !== '0) begin
            errors++;
            $display("FAIL rmid_async: got valid=%b last=%b data=%h busy=%b sent=%0d expected all zero",
                     tvalid_a, tlast_a, tdata_a, busy_a, sent_a);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if (tvalid_a !== 1'b1 || tdata_a !== '0 || sent_a !== '0) begin
            errors++; $display("FAIL rmid_restart: got valid=%b data=%h sent=%0d expected 1/0/0", tvalid_a, tdata_a, sent_a);
        end
        collect(0, 60, 0, -1, -1);
        checks++;
        if (q_data.size() != 8 || sent_a !== 32'd2) begin
            errors++; $display("FAIL rmid_run: got %0d beats sent=%0d expected 8/2", q_data.size(), sent_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        @(posedge clk); #1;
        test_backpressure();
        @(posedge clk); #1;
        test_gap();
        @(posedge clk); #1;
        test_stop();
        @(posedge clk); #1;
        test_start_stop_same();
        @(posedge clk); #1;
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_producer.md
DATA_PRODUCER -- requirements
Module: data_producer

Interface
REQ-001 Parameter DW, default 512: AXI-Stream data width in bits; SHALL be a multiple of 32, minimum 32.
REQ-002 Parameter PACKET_BEATS, default 16: beats per packet; range 1..65535.
REQ-003 Parameter GAP_CYCLES, default 0: idle cycles between packets; range 0..255.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a run.
REQ-007 stop  in  1  single-cycle request to end a run after the current packet.
REQ-008 packet_count  in  32  packets per run, sampled at start; 0 = continuous until stop.
REQ-009 AXIS_TX_TDATA  out  DW  stream data.
REQ-010 AXIS_TX_TVALID  out  1  stream valid.
REQ-011 AXIS_TX_TLAST  out  1  high on the final beat of each packet.
REQ-012 AXIS_TX_TREADY  in  1  downstream ready.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 packets_sent  out  32  packets fully accepted in the current run.

Function
REQ-015 FSM states: IDLE, SEND, GAP.
REQ-016 IDLE: start=1 -> SEND next cycle; latch packet_count; clear beat counter, packet counter, packets_sent, stop-pending flag.
REQ-017 Handshake = TVALID & TREADY on a rising edge; TVALID SHALL be high in SEND only.
REQ-018 Once TVALID is asserted, TVALID, TDATA and TLAST SHALL stay stable until handshake.
REQ-019 TDATA: every 32-bit lane = 32-bit beat counter; beat counter increments by 1 per handshake, wraps 0xFFFFFFFF -> 0, and is not cleared between packets within a run.
REQ-020 TLAST = 1 when beat-within-packet index == PACKET_BEATS-1; index wraps to 0 after the TLAST handshake.
REQ-021 On the TLAST handshake, packets_sent increments (saturating at 0xFFFFFFFF).
REQ-022 After the TLAST handshake: run ends (-> IDLE) if stop-pending, or packet_count != 0 and packets_sent+1 == packet_count; else -> GAP if GAP_CYCLES > 0, else remain in SEND with the next beat valid the following cycle (no bubble).
REQ-023 GAP: TVALID low for exactly GAP_CYCLES cycles, then -> SEND.
REQ-024 stop in SEND or GAP sets stop-pending; in GAP with stop-pending -> IDLE at the next edge; the current packet is never truncated.
REQ-025 stop and start in IDLE on the same cycle: start wins, stop ignored; start while busy ignored.
REQ-026 stop and TLAST handshake on the same cycle: run ends at that handshake.
REQ-027 packets_sent holds its value in IDLE until the next start.
REQ-028 First valid beat appears one cycle after start (latency 1).

Reset
REQ-029 reset asserted: state=IDLE; TVALID=0, TLAST=0, TDATA=0, busy=0, packets_sent=0; all counters and flags 0; effective immediately, without waiting for clk.
REQ-030 Reset mid-packet SHALL abort the packet with no TLAST; the first beat after release+start carries data 0.

Structure
REQ-031 Shared package: FSM state enum, LANE_W=32 constant, parameter range check helpers.
REQ-032 Single module; no sub-module required.
REQ-033 Registered outputs; no combinational path from TREADY to TVALID.

Verification
REQ-034 PACKET_BEATS=4, GAP_CYCLES=0, packet_count=2, TREADY=1 -> 8 consecutive beats, data 0..7, TLAST on beats 3 and 7, packets_sent=2, busy falls.
REQ-035 TREADY toggling 1/0 every cycle -> data/TLAST stable while TVALID & !TREADY; sequence 0..7 intact.
REQ-036 GAP_CYCLES=3, packet_count=2 -> exactly 3 TVALID-low cycles between beat 3 and beat 4.
REQ-037 packet_count=0, stop asserted on beat 1 of packet 2 (PACKET_BEATS=4) -> stream ends after data 7 with TLAST; packets_sent=2.
REQ-038 reset asserted during beat 2 -> TVALID=0 asynchronously; restart yields first data 0, packets_sent=0.
REQ-039 start and stop same cycle in IDLE -> run starts normally; start pulse during SEND -> no effect on counters.
